// File: rtl/router_fsm.sv
// router_fsm: control FSM of the 1x3 router.
//
// Decodes the header address, sequences router_reg through its load phases and raises
// busy toward the source whenever the packet has to stall.
//
// Optional feature: define ROUTER_FSM_WDOG_EN to build a stall watchdog. FIFO_FULL_STATE
// or WAIT_TILL_EMPTY held for WDOG_CYCLES cycles aborts the packet back to DECODE_ADDRESS
// and pulses wdog_err for one cycle. Without the macro wdog_err is tied low.
//
// Ports:
//   clock, resetn                 clock and asynchronous active-low reset
//   pkt_valid, data_in[1:0]       source valid and header address (3 = invalid)
//   fifo_full                     full flag of the currently selected FIFO
//   fifo_empty_0/1/2              per-FIFO empty flags
//   soft_reset_0/1/2              per-FIFO soft resets (only the latched port counts)
//   parity_done, low_pkt_valid    status from router_reg
//   write_enb_reg                 FIFO write enable (LOAD_DATA/LOAD_PARITY/LOAD_AFTER_FULL)
//   detect_add .. rst_int_reg     one-hot state strobes to router_reg
//   busy                          source must hold data
//   wdog_err                      one-cycle watchdog abort pulse
module router_fsm #(
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       write_enb_reg,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       wdog_err
);

  typedef enum logic [2:0] {
    StDecode = 3'd0,
    StLfd    = 3'd1,
    StLd     = 3'd2,
    StFfs    = 3'd3,
    StLaf    = 3'd4,
    StLp     = 3'd5,
    StCpe    = 3'd6,
    StWte    = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic       empty_din;   // empty flag of the port named by the incoming header
  logic       empty_addr;  // empty flag of the latched port
  logic       srst_hit;    // soft reset of the latched port
  logic       wdog_abort;

  always_comb begin
    empty_din = 1'b0;
    unique case (data_in)
      2'd0:    empty_din = fifo_empty_0;
      2'd1:    empty_din = fifo_empty_1;
      2'd2:    empty_din = fifo_empty_2;
      default: empty_din = 1'b0;
    endcase
  end

  // A latched address of 3 selects no port, so it never matches a soft reset.
  always_comb begin
    empty_addr = 1'b0;
    srst_hit   = 1'b0;
    unique case (addr_q)
      2'd0: begin
        empty_addr = fifo_empty_0;
        srst_hit   = soft_reset_0;
      end
      2'd1: begin
        empty_addr = fifo_empty_1;
        srst_hit   = soft_reset_1;
      end
      2'd2: begin
        empty_addr = fifo_empty_2;
        srst_hit   = soft_reset_2;
      end
      default: begin
        empty_addr = 1'b0;
        srst_hit   = 1'b0;
      end
    endcase
  end

`ifdef ROUTER_FSM_WDOG_EN
  // One spare count value so a soft reset landing on the last count cannot wrap.
  localparam int unsigned CntW = $clog2(WDOG_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WDOG_CYCLES - 1);

  logic [CntW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic            wdog_err_q, wdog_err_d;
  logic            stalled;

  assign stalled    = (state_q == StFfs) || (state_q == StWte);
  assign wdog_abort = stalled && !srst_hit && (wdog_cnt_q == CntLast);
  assign wdog_err_d = wdog_abort;

  always_comb begin
    wdog_cnt_d = '0;
    if (stalled && !wdog_abort) begin
      wdog_cnt_d = wdog_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  // WDOG_CYCLES only matters when the watchdog is built in.
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
  assign wdog_abort      = 1'b0;
  assign wdog_err        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    if ((state_q == StDecode) && pkt_valid) begin
      addr_d = data_in;
    end
    if (srst_hit || wdog_abort) begin
      state_d = StDecode;
    end else begin
      unique case (state_q)
        StDecode: begin
          // Address 3 never leaves DECODE: the packet is dropped.
          if (pkt_valid && (data_in != 2'd3)) begin
            state_d = empty_din ? StLfd : StWte;
          end
        end
        StLfd: state_d = StLd;
        StLd: begin
          if (fifo_full)       state_d = StFfs;
          else if (!pkt_valid) state_d = StLp;
        end
        StFfs: begin
          if (!fifo_full) state_d = StLaf;
        end
        StLaf: begin
          if (parity_done)        state_d = StDecode;
          else if (low_pkt_valid) state_d = StLp;
          else                    state_d = StLd;
        end
        StLp:  state_d = StCpe;
        StCpe: state_d = fifo_full ? StFfs : StDecode;
        StWte: begin
          if (empty_addr) state_d = StLfd;
        end
        default: state_d = StDecode;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StDecode;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Moore outputs: decoded from the state register only.
  assign detect_add    = (state_q == StDecode);
  assign lfd_state     = (state_q == StLfd);
  assign ld_state      = (state_q == StLd);
  assign laf_state     = (state_q == StLaf);
  assign full_state    = (state_q == StFfs);
  assign rst_int_reg   = (state_q == StCpe);
  assign write_enb_reg = (state_q == StLd) || (state_q == StLp) || (state_q == StLaf);
  assign busy          = !((state_q == StDecode) || (state_q == StLd));

endmodule

// File: tb/tb_router_fsm.sv
// Self-checking bench for router_fsm: constant-expectation vector table, hand-written
// multi-cycle sequences, then randomized stimulus against a behavioural model.
module tb_router_fsm;

  localparam int unsigned WdogCycles = 64;

  // Output vector order: {wen, detect, lfd, ld, laf, full, rst_int, busy, wdog_err}
  localparam logic [8:0] OutDec = 9'b010000000;
  localparam logic [8:0] OutLfd = 9'b001000010;
  localparam logic [8:0] OutLd  = 9'b100100000;
  localparam logic [8:0] OutFfs = 9'b000001010;
  localparam logic [8:0] OutLaf = 9'b100010010;
  localparam logic [8:0] OutLp  = 9'b100000010;
  localparam logic [8:0] OutCpe = 9'b000000110;
  localparam logic [8:0] OutWte = 9'b000000010;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] emp;
  logic [2:0] srst;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
  logic       full_state, rst_int_reg, busy, wdog_err;
  logic [8:0] outv;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  router_fsm #(.WDOG_CYCLES(WdogCycles)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty_0 (emp[0]),
    .fifo_empty_1 (emp[1]),
    .fifo_empty_2 (emp[2]),
    .soft_reset_0 (srst[0]),
    .soft_reset_1 (srst[1]),
    .soft_reset_2 (srst[2]),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .write_enb_reg(write_enb_reg),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .busy         (busy),
    .wdog_err     (wdog_err)
  );

  assign outv = {write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
                 rst_int_reg, busy, wdog_err};

  // ---------------- behavioural reference model ----------------
  typedef enum int {MDec, MLfd, MLd, MFfs, MLaf, MLp, MCpe, MWte} mst_e;
  mst_e m_st;
  int   m_addr;
  int   m_stall;
  bit   m_werr;

  task automatic model_reset();
    m_st = MDec; m_addr = 0; m_stall = 0; m_werr = 0;
  endtask

  function automatic logic [8:0] m_out();
    logic [8:0] o;
    case (m_st)
      MDec:    o = OutDec;
      MLfd:    o = OutLfd;
      MLd:     o = OutLd;
      MFfs:    o = OutFfs;
      MLaf:    o = OutLaf;
      MLp:     o = OutLp;
      MCpe:    o = OutCpe;
      default: o = OutWte;
    endcase
    o[0] = m_werr;
    return o;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_clock();
    mst_e nx    = m_st;
    bit   abort = 0;
    bit   sr    = (m_addr < 3) && srst[m_addr];
    bit   stall = (m_st == MFfs) || (m_st == MWte);
    int   d     = int'(data_in);
`ifdef ROUTER_FSM_WDOG_EN
    abort = stall && !sr && (m_stall == WdogCycles - 1);
`endif
    if (sr || abort) nx = MDec;
    else begin
      case (m_st)
        MDec: if (pkt_valid && d != 3) nx = emp[d] ? MLfd : MWte;
        MLfd: nx = MLd;
        MLd:  if (fifo_full) nx = MFfs; else if (!pkt_valid) nx = MLp;
        MFfs: if (!fifo_full) nx = MLaf;
        MLaf: nx = parity_done ? MDec : (low_pkt_valid ? MLp : MLd);
        MLp:  nx = MCpe;
        MCpe: nx = fifo_full ? MFfs : MDec;
        MWte: if (emp[m_addr]) nx = MLfd;
        default: nx = MDec;
      endcase
    end
    m_stall = (stall && !abort) ? m_stall + 1 : 0;
    if (m_st == MDec && pkt_valid) m_addr = d;
    m_werr = abort;
    m_st   = nx;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step(input logic pv, input logic [1:0] d, input logic f, input logic [2:0] e,
                      input logic [2:0] s, input logic pd, input logic lp);
    pkt_valid = pv; data_in = d; fifo_full = f; emp = e; srst = s;
    parity_done = pd; low_pkt_valid = lp;
    model_clock();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic       pv;
    logic [1:0] din;
    logic       full;
    logic [2:0] emp;
    logic [2:0] srst;
    logic       pd;
    logic       lp;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pv, input logic [1:0] d, input logic f, input logic [2:0] e,
                     input logic [2:0] s, input logic pd, input logic lp, input logic [8:0] x);
    vec_t v;
    v.pv = pv; v.din = d; v.full = f; v.emp = e; v.srst = s; v.pd = pd; v.lp = lp; v.exp = x;
    vecs.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n_lfd, n_wen, n_rst, n_ld, n_ffs;
    logic rf;

    resetn = 1'b0; pkt_valid = 0; data_in = 0; fifo_full = 0; emp = 3'b111; srst = 0;
    parity_done = 0; low_pkt_valid = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 check("reset_state", outv, OutDec);
    @(negedge clock) resetn = 1'b1;

    // ---- table: {pv, din, full, emp, srst, pd, lp} -> outputs after the clock ----
    // invalid address 3 stays in DECODE
    repeat (4) add(1, 3, 0, 3'b111, 0, 0, 0, OutDec);
    // port 2 not empty: WAIT_TILL_EMPTY for 5 cycles, then LFD
    repeat (5) add(1, 2, 0, 3'b011, 0, 0, 0, OutWte);
    add(1, 2, 0, 3'b111, 0, 0, 0, OutLfd);
    add(1, 2, 0, 3'b111, 0, 0, 0, OutLd);
    // full in LD -> FFS, release into LAF with low_pkt_valid -> LP -> CPE -> DECODE
    add(1, 2, 1, 3'b111, 0, 0, 0, OutFfs);
    add(1, 2, 1, 3'b111, 0, 0, 0, OutFfs);
    add(1, 2, 0, 3'b111, 0, 0, 1, OutLaf);
    add(1, 2, 0, 3'b111, 0, 0, 1, OutLp);
    add(0, 0, 0, 3'b111, 0, 0, 0, OutCpe);
    add(0, 0, 0, 3'b111, 0, 0, 0, OutDec);
    // addr 0 in LD: other ports' soft resets ignored, own one aborts
    add(1, 0, 0, 3'b111, 0, 0, 0, OutLfd);
    add(1, 0, 0, 3'b111, 0, 0, 0, OutLd);
    add(1, 0, 0, 3'b111, 3'b010, 0, 0, OutLd);
    add(1, 0, 0, 3'b111, 3'b100, 0, 0, OutLd);
    add(1, 0, 0, 3'b111, 3'b001, 0, 0, OutDec);
    // LP ignores full; CPE with full -> FFS; parity_done beats low_pkt_valid in LAF
    add(1, 1, 0, 3'b111, 0, 0, 0, OutLfd);
    add(1, 1, 0, 3'b111, 0, 0, 0, OutLd);
    add(0, 1, 0, 3'b111, 0, 0, 0, OutLp);
    add(0, 1, 1, 3'b111, 0, 0, 0, OutCpe);
    add(0, 1, 1, 3'b111, 0, 0, 0, OutFfs);
    add(0, 1, 0, 3'b111, 0, 1, 1, OutLaf);
    add(0, 1, 0, 3'b111, 0, 1, 1, OutDec);
    // LAF with neither flag returns to LD
    add(1, 1, 0, 3'b111, 0, 0, 0, OutLfd);
    add(1, 1, 0, 3'b111, 0, 0, 0, OutLd);
    add(1, 1, 1, 3'b111, 0, 0, 0, OutFfs);
    add(1, 1, 0, 3'b111, 0, 0, 0, OutLaf);
    add(1, 1, 0, 3'b111, 0, 0, 0, OutLd);
    add(0, 1, 0, 3'b111, 0, 0, 0, OutLp);
    add(0, 1, 0, 3'b111, 0, 0, 0, OutCpe);
    add(0, 1, 0, 3'b111, 0, 0, 0, OutDec);
    // WTE on port 2: soft resets of ports 0/1 ignored, port 2 aborts
    add(1, 2, 0, 3'b011, 0, 0, 0, OutWte);
    add(0, 0, 0, 3'b011, 3'b011, 0, 0, OutWte);
    add(0, 0, 0, 3'b011, 3'b100, 0, 0, OutDec);

    foreach (vecs[i]) begin
      step(vecs[i].pv, vecs[i].din, vecs[i].full, vecs[i].emp, vecs[i].srst, vecs[i].pd,
           vecs[i].lp);
      check($sformatf("vec%0d", i), outv, vecs[i].exp);
    end

    // ---- asynchronous reset in the middle of LD ----
    step(1, 0, 0, 3'b111, 0, 0, 0);
    step(1, 0, 0, 3'b111, 0, 0, 0);
    check("pre_async_ld", outv, OutLd);
    #2 resetn = 1'b0;
    #1 check("async_reset", outv, OutDec);
    model_reset();
    @(negedge clock) resetn = 1'b1;

    // ---- full packet to port 1: header, 8 payload, parity ----
    n_lfd = 0; n_wen = 0; n_rst = 0; n_ld = 0;
    for (int c = 0; c < 13; c++) begin
      if (c < 10) step(1, 1, 0, 3'b111, 0, 0, 0);
      else        step(0, 1, 0, 3'b111, 0, 0, 0);
      n_lfd += int'(lfd_state);
      n_wen += int'(write_enb_reg);
      n_rst += int'(rst_int_reg);
      n_ld  += int'(ld_state);
    end
    check_int("pkt_lfd_cycles", n_lfd, 1);
    check_int("pkt_ld_cycles", n_ld, 9);
    check_int("pkt_wen_cycles", n_wen, 10);
    check_int("pkt_rst_int_cycles", n_rst, 1);
    check("pkt_end", outv, OutDec);

    // ---- long stall in FFS ----
    step(1, 1, 0, 3'b111, 0, 0, 0);
    step(1, 1, 0, 3'b111, 0, 0, 0);
    step(1, 1, 1, 3'b111, 0, 0, 0);
    check("ffs_enter", outv, OutFfs);
    n_ffs = 1;
    for (int i = 0; i < 80; i++) begin
      step(1, 1, 1, 3'b111, 0, 0, 0);
      if (outv !== OutFfs) break;
      n_ffs++;
    end
`ifdef ROUTER_FSM_WDOG_EN
    check_int("wdog_ffs_cycles", n_ffs, WdogCycles);
    check("wdog_pulse", outv, OutDec | 9'b1);
    step(0, 0, 1, 3'b111, 0, 0, 0);
    check("wdog_pulse_end", outv, OutDec);
`else
    check_int("ffs_hold_cycles", n_ffs, 81);
    step(1, 1, 0, 3'b111, 0, 0, 0);
    check("ffs_release", outv, OutLaf);
    step(0, 1, 0, 3'b111, 0, 1, 0);
    check("laf_parity_done", outv, OutDec);
`endif

    // ---- randomized run against the model ----
    @(negedge clock) resetn = 1'b0;
    #1 check("rand_reset", outv, OutDec);
    model_reset();
    @(negedge clock) resetn = 1'b1;
    rf = 1'b0;
    for (int i = 0; i < 600; i++) begin
      logic [2:0] e, s;
      if ($urandom_range(0, 5) == 0) rf = ~rf;
      for (int b = 0; b < 3; b++) begin
        e[b] = ($urandom_range(0, 3) != 0);
        s[b] = ($urandom_range(0, 40) == 0);
      end
      step($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), rf, e, s,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
      check($sformatf("rand%0d", i), outv, m_out());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
